core_mem_port: RTL and testbench
================================

Name: core_mem_port

Overview:
- Core-side initiator for the shared, token-arbitrated block-RAM bus.
- Accepts one load/store at a time from a core's load/store unit over a valid/ready handshake.
- Holds the request until this core's token slot (cpu_en) arrives, drives the shared bus for exactly that slot, and for reads captures the RAM output one cycle later.
- Returns a single-cycle response pulse to the core; one instance per core, bus outputs muxed at top level by cpu_en.

Parameters:
- ADDR_WID, 32, request/bus address width.
- DATA_WID, 32, data width.
- TIMEOUT_CYC, 64, cycles spent in WAIT_SLOT before timeout fires (timeout exists only with MEM_PORT_TIMEOUT_EN).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- req_valid  input  1  core request valid.
- req_ready  output  1  port can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_WID  request address.
- req_wdata  input  DATA_WID  store data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_WID  load data, valid while rsp_valid=1 and held until the next load completes.
- cpu_en  input  1  this core's token slot from the memory controller.
- bus_oe  output  1  port is driving the bus this cycle.
- bus_we  output  1  bus write enable.
- bus_addr  output  ADDR_WID  bus address.
- bus_wdata  output  DATA_WID  bus write data.
- bus_rdata  input  DATA_WID  RAM read data, one cycle after the address.
- rsp_err  output  1  timeout flag (tied 0 without MEM_PORT_TIMEOUT_EN).

Behaviour:
- Reset (rst=0, async): state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; bus_oe=0; bus_we=0; bus_addr=0; bus_wdata=0; rsp_rdata=0; all latched request registers=0.
- States: IDLE, WAIT_SLOT, RD_DATA, RESP.
- IDLE:
  - req_ready=1.
  - req_valid=1 latches we/addr/wdata into local registers and moves to WAIT_SLOT.
  - A request is never issued to the bus in its acceptance cycle, even if cpu_en=1.
- WAIT_SLOT:
  - req_ready=0.
  - bus_oe = cpu_en (combinational from state and cpu_en); bus_we = latched_we & cpu_en.
  - bus_addr and bus_wdata come from the latched registers; they are zero when bus_oe=0, so OR-combining at top level is legal.
  - On a cpu_en=1 cycle: a store goes to RESP; a load goes to RD_DATA.
  - cpu_en=0 cycles are waited indefinitely.
- RD_DATA: bus_oe=0; at the end of the cycle bus_rdata is registered into rsp_rdata; next state RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; next state IDLE.
  - No response backpressure.
  - req_ready stays 0 in RESP.
- Latency from grant cycle G:
  - store: rsp_valid in cycle G+1.
  - load: data sampled at the end of G+1, rsp_valid in cycle G+2.
- Minimum request-to-request spacing is 3 cycles for a store and 4 for a load, plus token wait.
- rsp_rdata is unchanged by stores.
- cpu_en is ignored outside WAIT_SLOT, including while in RD_DATA; a second slot arriving then does not re-issue.
- Reset mid-operation drops the outstanding request; no response is produced.
- Address and data pass through unmodified; no alignment checking.

Optional Feature:
- Macro: MEM_PORT_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT_SLOT and increments every WAIT_SLOT cycle without cpu_en.
  - When the counter reaches TIMEOUT_CYC, the request is abandoned: nothing is driven on the bus, and the block goes to RESP with rsp_err=1 alongside rsp_valid. rsp_rdata is unchanged.
  - rsp_err is otherwise 0.
- Without the macro: no counter; rsp_err is tied 0.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the state encoding localparams (IDLE=2'd0, WAIT_SLOT=2'd1, RD_DATA=2'd2, RESP=2'd3);
  - RAM read latency RD_LAT=1;
  - default widths.
- No sub-module; a single FSM plus registers.
- Optional small sub-module mem_port_timer for the timeout counter, instantiated only under the macro.

Test Plan:
- Store, token 3 cycles away: req addr=0x10, wdata=0xDEADBEEF, req_we=1 with cpu_en pulsed 3 cycles later -> bus_oe=bus_we=1 only in that cycle with addr 0x10 / data 0xDEADBEEF; rsp_valid next cycle; rsp_rdata unchanged.
- Load: req addr=0x10 with bus_rdata=0xDEADBEEF presented the cycle after the grant -> rsp_valid at G+2 with rsp_rdata=0xDEADBEEF, held after rsp_valid drops.
- cpu_en=1 in the acceptance cycle and again 16 cycles later -> issue occurs only on the second slot; bus_oe=0 in the first.
- Reset asserted in RD_DATA -> all outputs return to their reset values immediately; no rsp_valid; req_ready=1 after release.
- Back-to-back requests with req_valid held high -> second accepted only in the cycle after RESP; cpu_en pulses during RD_DATA/RESP produce no bus_oe.
- With MEM_PORT_TIMEOUT_EN and TIMEOUT_CYC=8, cpu_en held 0 -> rsp_valid=rsp_err=1 one cycle after the counter reaches 8; bus_oe never asserted.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the token-arbitrated block-RAM bus: port FSM
// encoding, RAM read latency and default widths.
package mem_bus_pkg;

  localparam int unsigned DEFAULT_ADDR_WID    = 32;
  localparam int unsigned DEFAULT_DATA_WID    = 32;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 64;

  // RAM data appears this many cycles after the address is on the bus
  localparam int unsigned RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    RD_DATA   = 2'd2,
    RESP      = 2'd3
  } port_state_e;

endpackage

// File: rtl/mem_port_timer.sv
// Slot-wait timeout counter for core_mem_port. Only instantiated when
// MEM_PORT_TIMEOUT_EN is defined.
module mem_port_timer #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] count_q;

  assign expired_o = (count_q == CntW'(TIMEOUT_CYC));

  // Count slot-less waiting cycles, holding at the limit once reached
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (tick_i && !expired_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/core_mem_port.sv
// Core-side initiator for the shared token-arbitrated block-RAM bus.
// Accepts one load/store, waits for this core's token slot (cpu_en), drives
// the bus for exactly that slot and returns a one-cycle response pulse.
// Bus outputs are zero whenever bus_oe is low so instances can be OR-combined.
// Optional build macro: MEM_PORT_TIMEOUT_EN adds a slot-wait timeout that
// abandons the request and flags rsp_err.
module core_mem_port
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_WID    = DEFAULT_ADDR_WID,
  parameter int unsigned DATA_WID    = DEFAULT_DATA_WID,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_WID-1:0] req_addr,
  input  logic [DATA_WID-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [DATA_WID-1:0] rsp_rdata,
  input  logic                cpu_en,
  output logic                bus_oe,
  output logic                bus_we,
  output logic [ADDR_WID-1:0] bus_addr,
  output logic [DATA_WID-1:0] bus_wdata,
  input  logic [DATA_WID-1:0] bus_rdata,
  output logic                rsp_err
);

  port_state_e         state_q, state_d;
  logic                we_q;
  logic [ADDR_WID-1:0] addr_q;
  logic [DATA_WID-1:0] wdata_q;
  logic [DATA_WID-1:0] rdata_q;
  logic                timeout;

`ifdef MEM_PORT_TIMEOUT_EN
  logic err_q;

  mem_port_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q != WAIT_SLOT),
    .tick_i   ((state_q == WAIT_SLOT) && !cpu_en),
    .expired_o(timeout)
  );

  // Remember whether the pending response is an abandoned request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (state_q == WAIT_SLOT) begin
      err_q <= timeout;
    end
  end

  assign rsp_err = (state_q == RESP) && err_q;
`else
  logic [31:0] unusedTimeoutCyc;

  assign unusedTimeoutCyc = TIMEOUT_CYC;
  assign timeout          = 1'b0;
  assign rsp_err          = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/bus-enable decode; timeout beats a late grant
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    bus_oe    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        if (timeout) begin
          state_d = RESP;
        end else if (cpu_en) begin
          bus_oe  = 1'b1;
          state_d = we_q ? RESP : RD_DATA;
        end
      end
      RD_DATA: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus_we    = bus_oe && we_q;
  assign bus_addr  = bus_oe ? addr_q : '0;
  assign bus_wdata = bus_oe ? wdata_q : '0;
  assign rsp_rdata = rdata_q;

  // Latch the request when it is accepted in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if ((state_q == IDLE) && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Capture RAM read data the cycle after the load was issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (state_q == RD_DATA) begin
      rdata_q <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_core_mem_port.sv
// Self-checking bench for core_mem_port: directed scenarios followed by
// randomized transactions checked against a transaction-level model.
// Define MEM_PORT_TIMEOUT_EN to build and check the timeout variant.
module tb_core_mem_port;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_PORT_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
  localparam int MAX_DELAY  = 8;
  localparam int SLOT_GAP   = 8;
`else
  localparam int TB_TIMEOUT = 64;
  localparam int MAX_DELAY  = 12;
  localparam int SLOT_GAP   = 16;
`endif

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          cpu_en;
  logic          bus_oe;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          rsp_err;

  int checks = 0;
  int errors = 0;

  // Last load data the core should see on rsp_rdata
  logic [DW-1:0] rdataModel = '0;

  core_mem_port #(
    .ADDR_WID   (AW),
    .DATA_WID   (DW),
    .TIMEOUT_CYC(TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .cpu_en   (cpu_en),
    .bus_oe   (bus_oe),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge, then settle before checks
  task automatic applyStimulus(input logic v, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic en,
                               input logic [DW-1:0] rd);
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    cpu_en    = en;
    bus_rdata = rd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus released and no response this cycle
  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_oe"}, 32'(bus_oe), 32'd0);
    checkOutput({tag, "_we"}, 32'(bus_we), 32'd0);
    checkOutput({tag, "_addr"}, bus_addr, 32'd0);
    checkOutput({tag, "_wdata"}, bus_wdata, 32'd0);
    checkOutput({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
  endtask

  // Random unrelated request fields while the port is busy
  task automatic busyCycle(input logic holdValid, input logic en, input logic [DW-1:0] rd);
    applyStimulus(holdValid, 1'($urandom), $urandom, $urandom, en, rd);
  endtask

  // One transaction: accepted now, slot granted 'delay' cycles later,
  // response one cycle after the grant for a store, two for a load
  task automatic runTxn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int delay, input logic enAtAccept, input logic holdValid,
                        input logic [DW-1:0] rdVal);
    applyStimulus(1'b1, we, a, d, enAtAccept, $urandom);
    checkOutput("accept_ready", 32'(req_ready), 32'd1);
    checkQuiet("accept");
    for (int c = 1; c < delay; c++) begin
      busyCycle(holdValid, 1'b0, $urandom);
      checkOutput("wait_ready", 32'(req_ready), 32'd0);
      checkQuiet("wait");
    end
    busyCycle(holdValid, 1'b1, $urandom);
    checkOutput("grant_oe", 32'(bus_oe), 32'd1);
    checkOutput("grant_we", 32'(bus_we), 32'(we));
    checkOutput("grant_addr", bus_addr, a);
    checkOutput("grant_wdata", bus_wdata, d);
    checkOutput("grant_rspv", 32'(rsp_valid), 32'd0);
    checkOutput("grant_ready", 32'(req_ready), 32'd0);
    if (!we) begin
      busyCycle(holdValid, 1'($urandom), rdVal);
      checkOutput("rd_ready", 32'(req_ready), 32'd0);
      checkQuiet("rd");
      rdataModel = rdVal;
    end
    busyCycle(holdValid, 1'($urandom), $urandom);
    checkOutput("resp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("resp_rdata", rsp_rdata, rdataModel);
    checkOutput("resp_err", 32'(rsp_err), 32'd0);
    checkOutput("resp_ready", 32'(req_ready), 32'd0);
    checkOutput("resp_oe", 32'(bus_oe), 32'd0);
  endtask

  // Idle cycles between transactions; stray slots must not touch the bus
  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus(1'b0, 1'($urandom), $urandom, $urandom, 1'($urandom), $urandom);
      checkOutput("idle_ready", 32'(req_ready), 32'd1);
      checkOutput("idle_rdata", rsp_rdata, rdataModel);
      checkQuiet("idle");
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    cpu_en    = 1'b0;
    bus_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_err", 32'(rsp_err), 32'd0);
    checkQuiet("reset");
    @(negedge clk);
    rst = 1'b1;
    idleCycles(1);

    // Store with the slot three cycles after acceptance
    runTxn(1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0, 1'b0, 32'h0);
    idleCycles(1);
    // Load returning DEADBEEF, then held after the pulse
    runTxn(1'b0, 32'h10, 32'h0, 2, 1'b0, 1'b0, 32'hDEADBEEF);
    idleCycles(2);
    // Slot in the acceptance cycle is not used; the later one is
    runTxn(1'b1, 32'h20, 32'h1234_5678, SLOT_GAP, 1'b1, 1'b0, 32'h0);
    idleCycles(1);

    // Reset while waiting for read data drops the load
    applyStimulus(1'b1, 1'b0, 32'h44, 32'h55, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    checkOutput("rstmid_grant", 32'(bus_oe), 32'd1);
    @(negedge clk);
    cpu_en    = 1'b0;
    bus_rdata = 32'hA5A5_A5A5;
    rst       = 1'b0;
    #1;
    rdataModel = '0;
    checkOutput("rstmid_ready", 32'(req_ready), 32'd1);
    checkOutput("rstmid_rdata", rsp_rdata, 32'd0);
    checkOutput("rstmid_err", 32'(rsp_err), 32'd0);
    checkQuiet("rstmid");
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rstrel_ready", 32'(req_ready), 32'd1);
    idleCycles(3);

    // Back-to-back with req_valid held high throughout
    runTxn(1'b0, 32'h100, 32'h1, 1, 1'b0, 1'b1, 32'hCAFE_0001);
    runTxn(1'b1, 32'h104, 32'h2, 2, 1'b0, 1'b1, 32'h0);
    runTxn(1'b0, 32'h108, 32'h3, 1, 1'b0, 1'b1, 32'hCAFE_0003);
    idleCycles(1);

`ifdef MEM_PORT_TIMEOUT_EN
    // No slot ever arrives: abandoned after TB_TIMEOUT waiting cycles
    applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0);
    checkOutput("to_accept", 32'(req_ready), 32'd1);
    for (int c = 1; c <= TB_TIMEOUT + 1; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, $urandom);
      checkQuiet("to_wait");
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, $urandom);
    checkOutput("to_valid", 32'(rsp_valid), 32'd1);
    checkOutput("to_err", 32'(rsp_err), 32'd1);
    checkOutput("to_rdata", rsp_rdata, rdataModel);
    checkOutput("to_oe", 32'(bus_oe), 32'd0);
    idleCycles(1);
    checkOutput("to_err_clear", 32'(rsp_err), 32'd0);
`endif

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      runTxn(1'($urandom), $urandom, $urandom, int'($urandom_range(1, MAX_DELAY)),
             1'($urandom), 1'($urandom), $urandom);
      idleCycles(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
